// File: rtl/reduce_pkg.sv
// Shared types for the reduction engine: fold modes,
// controller states and the per-mode identity value.
package reduce_pkg;

   localparam int ACC_MAX = 64;

   typedef enum logic [1:0] {
      MODE_SUM = 2'd0,
      MODE_MIN = 2'd1,
      MODE_MAX = 2'd2,
      MODE_XOR = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_EMIT
   } state_e;

   // Starting accumulator so the first fold yields the operand.
   // Callers truncate to their own accumulator width w.
   function automatic logic [ACC_MAX-1:0] identity(
      mode_e m, int unsigned w);
      logic [ACC_MAX-1:0] pos;
      pos = (ACC_MAX'(1) << (w - 1)) - ACC_MAX'(1);
      case (m)
         MODE_MIN: identity = pos;
         MODE_MAX: identity = ~pos;
         default:  identity = '0;
      endcase
   endfunction

endpackage

// File: rtl/reduce_if.sv
// Host, RAM port b and result channel bundle of the
// reduction engine; master is the engine side.
interface reduce_if #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int ACC_WIDTH = 40
);
   logic                 req;
   logic [1:0]           mode;
   logic [DEPTH-1:0]     base;
   logic [DEPTH:0]       count;
   logic [31:0]          length;
   logic                 busy;
   logic [31:0]          address_b;
   logic [31:0]          din_b;
   logic                 we_b;
   logic                 oe_b;
   logic [WIDTH-1:0]     dout_b;
   logic [ACC_WIDTH-1:0] c_din;
   logic                 c_we;
   logic                 c_full;
   logic                 ovf;

   modport master (
      input  req, mode, base, count, length,
      input  dout_b, c_full,
      output busy, address_b, din_b, we_b, oe_b,
      output c_din, c_we, ovf
   );

   modport slave (
      output req, mode, base, count, length,
      output dout_b, c_full,
      input  busy, address_b, din_b, we_b, oe_b,
      input  c_din, c_we, ovf
   );
endinterface

// File: rtl/reduce_alu.sv
// Combinational fold of one sign-extended RAM word into
// the accumulator; overflow is sticky and only for sum.
module reduce_alu
   import reduce_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ACC_WIDTH = 40
) (
   input  mode_e                mode,
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]     din,
   input  logic                 ovf_in,
   output logic [ACC_WIDTH-1:0] acc_next,
   output logic                 ovf_next
);
   logic signed [ACC_WIDTH-1:0] a;
   logic signed [ACC_WIDTH-1:0] op;
   logic signed [ACC_WIDTH-1:0] sum;
   logic                        sum_ovf;

   // select the folded value for the latched mode
   always_comb begin
      a        = acc;
      op       = ACC_WIDTH'($signed(din));
      sum      = a + op;
      sum_ovf  = (a[ACC_WIDTH-1] == op[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
      acc_next = acc;
      ovf_next = 1'b0;
      case (mode)
         MODE_SUM: begin
            acc_next = sum;
            ovf_next = ovf_in | sum_ovf;
         end
         MODE_MIN: acc_next = (op < a) ? op : a;
         MODE_MAX: acc_next = (op > a) ? op : a;
         default:  acc_next = a ^ op;
      endcase
   end
endmodule

// File: rtl/reduce_unit.sv
// Streams a window of RAM words through reduce_alu and
// emits one result word on a backpressured channel.
module reduce_unit
   import reduce_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int ACC_WIDTH = 40,
   parameter int RD_LAT    = 1
) (
   input logic      clk,
   input logic      reset,
   reduce_if.master bus
);
   state_e                state_q, state_d;
   mode_e                 mode_q, mode_d;
   logic [31:0]           addr_q, addr_d;
   logic [DEPTH:0]        iss_q, iss_d;
   logic [DEPTH:0]        rem_q, rem_d;
   logic [RD_LAT-1:0]     vld_q, vld_d;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  sovf_q, sovf_d;
   logic                  busy_q, busy_d;
   logic                  oe_q, oe_d;
   logic                  c_we_q, c_we_d;
   logic [ACC_WIDTH-1:0]  c_din_q, c_din_d;
   logic                  ovf_q, ovf_d;

   logic [31:0]           avail;
   logic [DEPTH:0]        n_req;
   logic [ACC_WIDTH-1:0]  ident;
   logic                  fire;
   logic [ACC_WIDTH-1:0]  fold_acc;
   logic                  fold_ovf;

   reduce_alu #(
      .WIDTH    (WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
   ) u_alu (
      .mode    (mode_q),
      .acc     (acc_q),
      .din     (bus.dout_b),
      .ovf_in  (sovf_q),
      .acc_next(fold_acc),
      .ovf_next(fold_ovf)
   );

   // next state: window clamp, issue, fold and emit control
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      iss_d   = iss_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      sovf_d  = sovf_q;
      busy_d  = busy_q;
      oe_d    = oe_q;
      c_we_d  = c_we_q;
      c_din_d = c_din_q;
      ovf_d   = ovf_q;

      avail = (bus.length > 32'(bus.base)) ?
              bus.length - 32'(bus.base) : '0;
      n_req = (32'(bus.count) < avail) ?
              bus.count : avail[DEPTH:0];
      ident = ACC_WIDTH'(identity(mode_e'(bus.mode),
                                  ACC_WIDTH));
      fire  = vld_q[RD_LAT-1];
      vld_d = (vld_q << 1) | RD_LAT'(oe_q);

      if (fire) begin
         acc_d  = fold_acc;
         sovf_d = fold_ovf;
         rem_d  = rem_q - 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               mode_d = mode_e'(bus.mode);
               acc_d  = ident;
               sovf_d = 1'b0;
               busy_d = 1'b1;
               rem_d  = n_req;
               if (n_req != '0) begin
                  state_d = S_ISSUE;
                  oe_d    = 1'b1;
                  addr_d  = 32'(bus.base);
                  iss_d   = n_req - 1'b1;
               end else begin
                  state_d = S_EMIT;
                  c_we_d  = 1'b1;
                  c_din_d = ident;
                  ovf_d   = 1'b0;
               end
            end
         end
         S_ISSUE: begin
            if (iss_q == '0) begin
               state_d = S_DRAIN;
               oe_d    = 1'b0;
            end else begin
               addr_d = addr_q + 32'd1;
               iss_d  = iss_q - 1'b1;
            end
         end
         S_DRAIN: begin
            if (fire && rem_q == 1) begin
               state_d = S_EMIT;
               c_we_d  = 1'b1;
               c_din_d = fold_acc;
               ovf_d   = fold_ovf;
            end
         end
         default: begin
            if (!bus.c_full) begin
               state_d = S_IDLE;
               c_we_d  = 1'b0;
               busy_d  = 1'b0;
            end
         end
      endcase
   end

   // controller and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_SUM;
         addr_q  <= '0;
         iss_q   <= '0;
         rem_q   <= '0;
         vld_q   <= '0;
         acc_q   <= '0;
         sovf_q  <= 1'b0;
         busy_q  <= 1'b0;
         oe_q    <= 1'b0;
         c_we_q  <= 1'b0;
         c_din_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         iss_q   <= iss_d;
         rem_q   <= rem_d;
         vld_q   <= vld_d;
         acc_q   <= acc_d;
         sovf_q  <= sovf_d;
         busy_q  <= busy_d;
         oe_q    <= oe_d;
         c_we_q  <= c_we_d;
         c_din_q <= c_din_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.address_b = addr_q;
   assign bus.din_b     = '0;
   assign bus.we_b      = 1'b0;
   assign bus.oe_b      = oe_q;
   assign bus.c_we      = c_we_q;
   assign bus.c_din     = c_din_q;
   assign bus.ovf       = ovf_q;
endmodule
